// File: rtl/syscall_responder.sv
// Syscall service unit: print signed int (double-dabble to ASCII), print char, halt.
// Ports: clock/reset, syscall_valid/funct/param1 in, syscall_busy stall, char_valid/data/ready console, halted.
module syscall_responder #(
    parameter int unsigned PRINT_INT_FUNCT  = 1,
    parameter int unsigned PRINT_CHAR_FUNCT = 11,
    parameter int unsigned EXIT_FUNCT       = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    output logic        syscall_busy,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE, CONVERT, SIGN, EMIT, CHAR, HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [7:0]  char_q, char_d;

    logic [39:0] bcd_adj;
    logic [39:0] bcd_shift;
    logic [4:0]  lead;
    logic [3:0]  digit;

    // Double-dabble step, plus the index of the leading nonzero digit of the
    // step result so EMIT starts there and never spends cycles on zeros.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
        bcd_shift = {bcd_adj[38:0], mag_q[31]};
        lead = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0)
                lead = 5'(i);
        end
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (cnt_q == 5'(i))
                digit = bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        char_d     = char_q;
        char_valid = 1'b0;
        char_data  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (syscall_valid) begin
                    if (syscall_funct == 32'(PRINT_CHAR_FUNCT)) begin
                        char_d  = syscall_param1[7:0];
                        state_d = CHAR;
                    end else if (syscall_funct == 32'(EXIT_FUNCT)) begin
                        state_d = HALT;
                    end else if (syscall_funct == 32'(PRINT_INT_FUNCT)) begin
                        mag_d   = syscall_param1[31] ? (~syscall_param1 + 32'd1)
                                                     : syscall_param1;
                        neg_d   = syscall_param1[31];
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[30:0], 1'b0};
                if (cnt_q == 5'd31) begin
                    cnt_d   = lead;
                    state_d = neg_q ? SIGN : EMIT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            SIGN: begin
                char_valid = 1'b1;
                char_data  = 8'h2D;
                if (char_ready)
                    state_d = EMIT;
            end
            EMIT: begin
                char_valid = 1'b1;
                char_data  = 8'h30 + {4'h0, digit};
                if (char_ready) begin
                    if (cnt_q == 5'd0)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q - 5'd1;
                end
            end
            CHAR: begin
                char_valid = 1'b1;
                char_data  = char_q;
                if (char_ready)
                    state_d = IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            char_q  <= char_d;
        end
    end

    assign syscall_busy = (state_q != IDLE);
    assign halted       = (state_q == HALT);

endmodule
